// File: rtl/addsub_share_if.sv
// Request/response bundle between two ALU requesters, the shared add/sub controller and the result consumer.
interface addsub_share_if #(
    parameter int WIDTH = 32
);
    logic             r0_valid;
    logic             r0_ready;
    logic             r0_sub;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;

    logic             r1_valid;
    logic             r1_ready;
    logic             r1_sub;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_carry;
    logic             resp_zero;
    logic             resp_ovf;

    modport master (
        output r0_valid, r0_sub, r0_a, r0_b,
        output r1_valid, r1_sub, r1_a, r1_b,
        output resp_ready,
        input  r0_ready, r1_ready,
        input  resp_valid, resp_id, resp_result, resp_carry, resp_zero, resp_ovf
    );

    modport slave (
        input  r0_valid, r0_sub, r0_a, r0_b,
        input  r1_valid, r1_sub, r1_a, r1_b,
        input  resp_ready,
        output r0_ready, r1_ready,
        output resp_valid, resp_id, resp_result, resp_carry, resp_zero, resp_ovf
    );
endinterface

// File: rtl/addsub_share_ctrl.sv
// Shares one add/sub datapath between two requesters; one op in flight, tagged held response.
// Build option ADDSUB_FIXED_PRIO_EN: r0 always wins ties instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; winner sees ready
// EXEC  | computing from latched operands into resp regs
// RESP  | result held on response channel until consumed
module addsub_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    addsub_share_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             any_valid;
    logic             winner;
    logic             handshake;

    logic             sub_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;
    logic             rid_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf_calc;

    assign any_valid = bus.r0_valid | bus.r1_valid;
    assign handshake = (state_q == S_IDLE) && any_valid;

`ifdef ADDSUB_FIXED_PRIO_EN
    assign winner = ~bus.r0_valid;
`else
    logic last_grant_q;

    always_comb begin
        if (bus.r0_valid && bus.r1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~bus.r0_valid;
        end
    end

    // reset to 1 so r0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (handshake) begin
            last_grant_q <= winner;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.r0_ready    = 1'b0;
        bus.r1_ready    = 1'b0;
        if (handshake) begin
            bus.r0_ready = ~winner;
            bus.r1_ready = winner;
        end
        bus.resp_valid  = (state_q == S_RESP);
        bus.resp_id     = rid_q;
        bus.resp_result = result_q;
        bus.resp_carry  = carry_q;
        bus.resp_zero   = zero_q;
        bus.resp_ovf    = ovf_q;
    end

    // operands are captured only on the handshake edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= 1'b0;
        end else if (handshake) begin
            sub_q <= winner ? bus.r1_sub : bus.r0_sub;
            a_q   <= winner ? bus.r1_a   : bus.r0_a;
            b_q   <= winner ? bus.r1_b   : bus.r0_b;
            id_q  <= winner;
        end
    end

    // subtraction as A + ~B + 1, so carry=1 means no borrow
    assign b_eff    = sub_q ? ~b_q : b_q;
    assign sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};
    assign ovf_calc = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rid_q    <= 1'b0;
        end else if (state_q == S_EXEC) begin
            result_q <= sum[WIDTH-1:0];
            carry_q  <= sum[WIDTH];
            zero_q   <= ~|sum[WIDTH-1:0];
            ovf_q    <= ovf_calc;
            rid_q    <= id_q;
        end
    end
endmodule
